// File: rtl/data_mem_controller.sv
// Data memory sequencer: one load/store at a time, sub-word stores
// done as read-modify-write against a word-only, 1-cycle-read memory.
module data_mem_controller #(
    parameter int ADDR_BITS = 16,
    parameter int WORD_LEN  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_error,
    output logic                mem_en,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_RD_ISSUE,
        S_RD_DATA,
        S_WR_ISSUE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                wen_q;
    logic [2:0]          f3_q;
    logic [WORD_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] data_q, data_d;
    logic                resp_valid_q;
    logic                resp_error_q;
    logic [WORD_LEN-1:0] resp_rdata_q;

    logic                accept;
    logic                req_err;
    logic                f3_ok;
    logic                misal;
    logic                oor;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [WORD_LEN-1:0] load_val;
    logic [WORD_LEN-1:0] merged;

    assign accept = req_valid && req_ready;

    // Classify the incoming request before it is accepted
    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_wen;
            default:                f3_ok = 1'b0;
        endcase
        misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
             || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        oor     = (req_addr >> ADDR_BITS) != '0;
        req_err = !f3_ok || misal || oor;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'd0, lane_b};
            3'b101:  load_val = {16'd0, lane_h};
            default: load_val = mem_rdata;
        endcase
        merged = mem_rdata;
        if (f3_q[0]) begin
            if (addr_q[1]) merged[31:16] = data_q[15:0];
            else           merged[15:0]  = data_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and working-data selection
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d = req_wdata;
                    if (req_err)
                        state_d = S_ERR;
                    else if (req_wen && (req_funct3 == 3'b010))
                        state_d = S_WR_ISSUE;
                    else
                        state_d = S_RD_ISSUE;
                end
            end
            S_ERR:      state_d = S_IDLE;
            S_RD_ISSUE: state_d = S_RD_DATA;
            S_RD_DATA: begin
                data_d  = wen_q ? merged : load_val;
                state_d = wen_q ? S_WR_ISSUE : S_DONE;
            end
            S_WR_ISSUE: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and latched request
    always_comb begin
        req_ready = (state_q == S_IDLE) && !reset;
        mem_en    = (state_q == S_RD_ISSUE) || (state_q == S_WR_ISSUE);
        mem_wen   = (state_q == S_WR_ISSUE) && !reset;
        mem_addr  = mem_en ? {addr_q[WORD_LEN-1:2], 2'b00} : '0;
        mem_wdata = (state_q == S_WR_ISSUE) ? data_q : '0;
    end

    // Request latch, working word and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wen_q        <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            if (accept) begin
                wen_q  <= req_wen;
                f3_q   <= req_funct3;
                addr_q <= req_addr;
            end
            data_q       <= data_d;
            resp_valid_q <= (state_q == S_ERR) || (state_q == S_DONE);
            resp_error_q <= (state_q == S_ERR);
            resp_rdata_q <= ((state_q == S_DONE) && !wen_q) ? data_q : '0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: memory model, reference model and
// a response scoreboard checking data, error flag and latency.
module tb_data_mem_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_en;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_mem = 0;
    int prev_lat = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_raddr = '0;

    data_mem_controller dut (
        .clock      (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // single-port word memory with registered read
    always @(posedge clk) begin
        if (mem_en && mem_wen) mem[mem_addr[15:2]] <= mem_wdata;
        if (mem_en && !mem_wen) mem_rdata <= mem[mem_addr[15:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic wen, input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w;
        logic [31:0] t;
        logic [31:0] m;
        int          sb;
        int          shh;
        bit          legal;
        e.rdata = '0;
        e.err   = 1'b0;
        e.lat   = 0;
        e.t0    = 0;
        legal = wen ? (f3 <= 3'd2)
                    : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal || a >= 32'h0001_0000
            || ((f3 == 3'd1 || f3 == 3'd5) && a[0])
            || (f3 == 3'd2 && a[1:0] != 2'b00)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        w   = ref_mem[a[15:2]];
        sb  = 8 * int'(a[1:0]);
        shh = a[1] ? 16 : 0;
        if (!wen) begin
            e.lat = 3;
            case (f3)
                3'd0: begin t = w >> sb;  e.rdata = {{24{t[7]}}, t[7:0]}; end
                3'd1: begin t = w >> shh; e.rdata = {{16{t[15]}}, t[15:0]}; end
                3'd4: begin t = w >> sb;  e.rdata = t & 32'hFF; end
                3'd5: begin t = w >> shh; e.rdata = t & 32'hFFFF; end
                default: e.rdata = w;
            endcase
        end else begin
            case (f3)
                3'd0: begin
                    m = 32'hFF << sb;
                    ref_mem[a[15:2]] = (w & ~m) | ((wd & 32'hFF) << sb);
                    e.lat = 4;
                end
                3'd1: begin
                    m = 32'hFFFF << shh;
                    ref_mem[a[15:2]] = (w & ~m) | ((wd & 32'hFFFF) << shh);
                    e.lat = 4;
                end
                default: begin
                    ref_mem[a[15:2]] = wd;
                    e.lat = 2;
                end
            endcase
        end
        return e;
    endfunction

    // response checker and memory-side observer
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_resp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                chk("latency", cyc - e.t0, e.lat);
            end
        end
        if (mem_en) n_mem++;
        if (mem_en && mem_wen) begin
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (mem_en && !mem_wen) last_raddr = mem_addr;
    end

    task automatic send(input logic wen, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit resp_exp, input bit chk_busy);
        int   waited;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        waited = 0;
        while (!req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (chk_busy) chk("busy_cycles", waited, prev_lat);
        if (resp_exp) begin
            e = model(wen, f3, a, wd);
            e.t0 = cyc + 1;
            sb_q.push_back(e);
            prev_lat = e.lat;
        end
    endtask

    task automatic drop();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic one(input logic wen, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        send(wen, f3, a, wd, 1'b1, 1'b0);
        drop();
        drain();
    endtask

    logic        bw  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic [2:0]  bf3 [8] = '{2, 0, 0, 2, 1, 5, 1, 1};
    logic [31:0] ba  [8] = '{32'h50, 32'h51, 32'h53, 32'h50,
                             32'h53, 32'h52, 32'h52, 32'h52};
    logic [31:0] bd  [8] = '{32'h0123_4567, 0, 32'hFFFF_FF9C, 0,
                             32'h1111, 0, 32'h0000_BEEF, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        one(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        chk("sw_waddr", last_waddr, 32'h10);
        one(1'b0, 3'd2, 32'h10, 32'd0);
        chk("lw_raddr", last_raddr, 32'h10);

        one(1'b1, 3'd2, 32'h20, 32'h1122_3344);
        one(1'b1, 3'd0, 32'h22, 32'h0000_00AA);
        chk("sb_waddr", last_waddr, 32'h20);
        chk("sb_wdata", last_wdata, 32'h11AA_3344);
        one(1'b0, 3'd2, 32'h20, 32'd0);

        one(1'b1, 3'd2, 32'h30, 32'h80F0_7F01);
        one(1'b0, 3'd0, 32'h33, 32'd0);
        one(1'b0, 3'd4, 32'h33, 32'd0);
        one(1'b0, 3'd1, 32'h32, 32'd0);
        one(1'b0, 3'd5, 32'h30, 32'd0);

        n0 = n_mem;
        one(1'b0, 3'd2, 32'h0000_0006, 32'd0);
        one(1'b1, 3'd1, 32'h0000_0005, 32'h1234);
        one(1'b0, 3'd3, 32'h0000_0010, 32'd0);
        one(1'b0, 3'd2, 32'h0001_0000, 32'd0);
        chk("err_no_mem", n_mem, n0);

        one(1'b1, 3'd2, 32'h40, 32'h0BAD_F00D);
        send(1'b1, 3'd0, 32'h41, 32'h0000_0077, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_issue", {31'd0, mem_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_gate_wen", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        one(1'b0, 3'd2, 32'h40, 32'd0);

        for (int i = 0; i < 8; i++)
            send(bw[i], bf3[i], ba[i], bd[i], 1'b1, i != 0);
        drop();
        drain();

        chk("pending", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
